// File: rtl/rx_cmd_decoder_port2_if.sv
// RX-side bus bundle for the port-2 command decoder: show-ahead RX FIFOs in, PI/ray FIFO writes out.
// master = decoder side, slave = FIFO side.
interface rx_cmd_decoder_port2_if #(
    parameter int unsigned AVL_SIZE    = 8,
    parameter int unsigned BYTE_SIZE   = 8,
    parameter int unsigned IP_SIZE     = 32,
    parameter int unsigned MAC_SIZE    = 48,
    parameter int unsigned FIFO_LENGTH = 16
);
    localparam int unsigned STATUS_W = 2 * BYTE_SIZE + IP_SIZE + MAC_SIZE;

    logic [AVL_SIZE-1:0]    rx_fifo_data;
    logic                   rx_fifo_data_empty;
    logic                   rx_fifo_data_read;
    logic [STATUS_W-1:0]    rx_fifo_status;
    logic                   rx_fifo_status_empty;
    logic                   rx_fifo_status_read;
    logic                   pi_wrreq_input_fifo;
    logic [FIFO_LENGTH-1:0] pi_wrdata_input_fifo;
    logic                   pi_wrfull_input_fifo;
    logic                   ray_wrreq_fifo;
    logic [FIFO_LENGTH-1:0] ray_wrdata_fifo;
    logic                   ray_wrfull_fifo;

    modport master (
        input  rx_fifo_data, rx_fifo_data_empty, rx_fifo_status, rx_fifo_status_empty,
        input  pi_wrfull_input_fifo, ray_wrfull_fifo,
        output rx_fifo_data_read, rx_fifo_status_read,
        output pi_wrreq_input_fifo, pi_wrdata_input_fifo, ray_wrreq_fifo, ray_wrdata_fifo
    );

    modport slave (
        output rx_fifo_data, rx_fifo_data_empty, rx_fifo_status, rx_fifo_status_empty,
        output pi_wrfull_input_fifo, ray_wrfull_fifo,
        input  rx_fifo_data_read, rx_fifo_status_read,
        input  pi_wrreq_input_fifo, pi_wrdata_input_fifo, ray_wrreq_fifo, ray_wrdata_fifo
    );
endinterface

// File: rtl/rx_cmd_decoder_port2.sv
// Port-2 RX command decoder: checks 0xA5 + two 16-bit word framing, commits PI/ray words atomically.
// Error counters are built only when RX_ERROR_COUNTERS_EN is defined; otherwise tied to 0.
module rx_cmd_decoder_port2 #(
    parameter int unsigned AVL_SIZE    = 8,
    parameter int unsigned BYTE_SIZE   = 8,
    parameter int unsigned IP_SIZE     = 32,
    parameter int unsigned MAC_SIZE    = 48,
    parameter int unsigned FIFO_LENGTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    rx_cmd_decoder_port2_if.master bus,
    output logic [MAC_SIZE-1:0]    destination_mac,
    output logic [IP_SIZE-1:0]     destination_ip,
    output logic [15:0]            err_len_count,
    output logic [15:0]            err_hdr_count,
    output logic [15:0]            err_drop_count
);
    localparam int unsigned BYTE_IN_FIFO = FIFO_LENGTH / BYTE_SIZE;
    localparam int unsigned STATUS_W     = 2 * BYTE_SIZE + IP_SIZE + MAC_SIZE;
    localparam int unsigned SHIFT_W      = 2 * FIFO_LENGTH;
    localparam logic [15:0] EXP_LEN      = 16'(2 * BYTE_IN_FIFO + 1);
    localparam logic [AVL_SIZE-1:0] HDR_BYTE = AVL_SIZE'(8'hA5);

    typedef enum logic [2:0] {StIdle, StCheck, StHeader, StPayload, StCommit, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [15:0]            len_q, len_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [IP_SIZE-1:0]     ip_q, ip_d;
    logic [MAC_SIZE-1:0]    mac_q, mac_d;
    logic [SHIFT_W-1:0]     shift_q, shift_d;
    logic                   wr_q, wr_d;
    logic [FIFO_LENGTH-1:0] pi_data_q, pi_data_d;
    logic [FIFO_LENGTH-1:0] ray_data_q, ray_data_d;
    logic [IP_SIZE-1:0]     dst_ip_q, dst_ip_d;
    logic [MAC_SIZE-1:0]    dst_mac_q, dst_mac_d;
    logic                   status_pop, data_pop;
    logic                   len_err_inc, hdr_err_inc, drop_inc;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        ip_d        = ip_q;
        mac_d       = mac_q;
        shift_d     = shift_q;
        wr_d        = 1'b0;
        pi_data_d   = pi_data_q;
        ray_data_d  = ray_data_q;
        dst_ip_d    = dst_ip_q;
        dst_mac_d   = dst_mac_q;
        status_pop  = 1'b0;
        data_pop    = 1'b0;
        len_err_inc = 1'b0;
        hdr_err_inc = 1'b0;
        drop_inc    = 1'b0;
        case (state_q)
            StIdle: begin
                if (!bus.rx_fifo_status_empty) begin
                    status_pop = 1'b1;
                    len_d      = bus.rx_fifo_status[STATUS_W-1 -: 16];
                    ip_d       = bus.rx_fifo_status[MAC_SIZE +: IP_SIZE];
                    mac_d      = bus.rx_fifo_status[MAC_SIZE-1:0];
                    cnt_d      = bus.rx_fifo_status[STATUS_W-1 -: 16];
                    state_d    = StCheck;
                end
            end
            StCheck: begin
                if (len_q == 16'd0) begin
                    state_d = StIdle;
                end else if (len_q != EXP_LEN) begin
                    len_err_inc = 1'b1;
                    state_d     = StDrain;
                end else begin
                    state_d = StHeader;
                end
            end
            StHeader: begin
                if (!bus.rx_fifo_data_empty) begin
                    data_pop = 1'b1;
                    cnt_d    = cnt_q - 16'd1;
                    if (bus.rx_fifo_data == HDR_BYTE) begin
                        state_d = StPayload;
                    end else begin
                        hdr_err_inc = 1'b1;
                        state_d     = StDrain;
                    end
                end
            end
            StPayload: begin
                if (!bus.rx_fifo_data_empty) begin
                    data_pop = 1'b1;
                    cnt_d    = cnt_q - 16'd1;
                    shift_d  = {shift_q[SHIFT_W-AVL_SIZE-1:0], bus.rx_fifo_data};
                    // Commit is decided on the edge into StCommit so the strobes are
                    // registered yet land in the StCommit cycle.
                    if (cnt_q == 16'd1) begin
                        state_d = StCommit;
                        if (!bus.pi_wrfull_input_fifo && !bus.ray_wrfull_fifo) begin
                            wr_d       = 1'b1;
                            pi_data_d  = shift_d[SHIFT_W-1 -: FIFO_LENGTH];
                            ray_data_d = shift_d[FIFO_LENGTH-1:0];
                            dst_ip_d   = ip_q;
                            dst_mac_d  = mac_q;
                        end else begin
                            drop_inc = 1'b1;
                        end
                    end
                end
            end
            StCommit: state_d = StIdle;
            StDrain: begin
                if (cnt_q == 16'd0) begin
                    state_d = StIdle;
                end else if (!bus.rx_fifo_data_empty) begin
                    data_pop = 1'b1;
                    cnt_d    = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            len_q      <= '0;
            cnt_q      <= '0;
            ip_q       <= '0;
            mac_q      <= '0;
            shift_q    <= '0;
            wr_q       <= 1'b0;
            pi_data_q  <= '0;
            ray_data_q <= '0;
            dst_ip_q   <= '0;
            dst_mac_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            ip_q       <= ip_d;
            mac_q      <= mac_d;
            shift_q    <= shift_d;
            wr_q       <= wr_d;
            pi_data_q  <= pi_data_d;
            ray_data_q <= ray_data_d;
            dst_ip_q   <= dst_ip_d;
            dst_mac_q  <= dst_mac_d;
        end
    end

    // Pops must follow the show-ahead empty flag in the same cycle; reset blocks all pops.
    assign bus.rx_fifo_status_read  = status_pop & reset_n;
    assign bus.rx_fifo_data_read    = data_pop & reset_n;
    assign bus.pi_wrreq_input_fifo  = wr_q;
    assign bus.ray_wrreq_fifo       = wr_q;
    assign bus.pi_wrdata_input_fifo = pi_data_q;
    assign bus.ray_wrdata_fifo      = ray_data_q;
    assign destination_ip           = dst_ip_q;
    assign destination_mac          = dst_mac_q;

`ifdef RX_ERROR_COUNTERS_EN
    logic [15:0] err_len_q, err_len_d, err_hdr_q, err_hdr_d, err_drop_q, err_drop_d;

    always_comb begin
        err_len_d  = err_len_q;
        err_hdr_d  = err_hdr_q;
        err_drop_d = err_drop_q;
        if (len_err_inc && (err_len_q != 16'hFFFF)) err_len_d = err_len_q + 16'd1;
        if (hdr_err_inc && (err_hdr_q != 16'hFFFF)) err_hdr_d = err_hdr_q + 16'd1;
        if (drop_inc && (err_drop_q != 16'hFFFF))   err_drop_d = err_drop_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_len_q  <= '0;
            err_hdr_q  <= '0;
            err_drop_q <= '0;
        end else begin
            err_len_q  <= err_len_d;
            err_hdr_q  <= err_hdr_d;
            err_drop_q <= err_drop_d;
        end
    end

    assign err_len_count  = err_len_q;
    assign err_hdr_count  = err_hdr_q;
    assign err_drop_count = err_drop_q;
`else
    logic unused_err_inc;
    assign unused_err_inc = len_err_inc ^ hdr_err_inc ^ drop_inc;
    assign err_len_count  = '0;
    assign err_hdr_count  = '0;
    assign err_drop_count = '0;
`endif
endmodule
